// File: rtl/data_ram_dp_sweep.sv
// True dual-port data RAM with a hardware clear sweep, read-valid strobes and range checking.
// Define DATA_RAM_OUT_REG_EN to add a second output register stage (read latency 2).
module data_ram_dp_sweep #(
    parameter int DATA_WIDTH     = 24,
    parameter int DEPTH          = 90000,
    parameter int ADDR_WIDTH     = 17,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_start,
    output logic                  busy,
    input  logic                  read_enable_a,
    input  logic                  write_enable_a,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic [DATA_WIDTH-1:0] write_data_a,
    output logic [DATA_WIDTH-1:0] read_data_a,
    output logic                  read_valid_a,
    output logic                  addr_error_a,
    input  logic                  read_enable_b,
    input  logic                  write_enable_b,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0] write_data_b,
    output logic [DATA_WIDTH-1:0] read_data_b,
    output logic                  read_valid_b,
    output logic                  addr_error_b
);

    localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    state_t           state, state_next;
    logic [IDX_W-1:0] ptr, ptr_next;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic             in_range_a, in_range_b;
    logic [IDX_W-1:0] idx_a, idx_b;
    logic             wr_a, wr_b, rd_a, rd_b, err_a, err_b;

    logic [DATA_WIDTH-1:0] data_a_p0, data_b_p0;
    logic                  vld_a_p0, vld_b_p0, err_a_p0, err_b_p0;

    assign busy = (state == CLEAR);

    assign in_range_a = ({1'b0, address_a} < DEPTH_LIM);
    assign in_range_b = ({1'b0, address_b} < DEPTH_LIM);
    assign idx_a      = address_a[IDX_W-1:0];
    assign idx_b      = address_b[IDX_W-1:0];

    // Port A wins a same-address write collision; B's write is silently discarded.
    assign wr_a  = write_enable_a && in_range_a && !busy;
    assign wr_b  = write_enable_b && in_range_b && !busy && !(wr_a && (idx_a == idx_b));
    assign rd_a  = read_enable_a && in_range_a && !busy;
    assign rd_b  = read_enable_b && in_range_b && !busy;
    assign err_a = !busy && (read_enable_a || write_enable_a) && !in_range_a;
    assign err_b = !busy && (read_enable_b || write_enable_b) && !in_range_b;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RESET_STATE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            CLEAR: begin
                ptr_next = ptr + IDX_W'(1);
                if (ptr == LAST_IDX) begin
                    state_next = READY;
                    ptr_next   = '0;
                end
            end
            READY: begin
                if (clear_start) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = RESET_STATE;
                ptr_next   = '0;
            end
        endcase
    end

    // The array itself has no reset; zeroing is done only by the sweep.
    always_ff @(posedge clock) begin
        if (busy) begin
            mem[ptr] <= '0;
        end else begin
            if (wr_a) mem[idx_a] <= write_data_a;
            if (wr_b) mem[idx_b] <= write_data_b;
        end
    end

    // Stage p0: read-first array read; data is masked to 0 unless the read was accepted.
    always_ff @(posedge clock) begin
        if (rd_a) data_a_p0 <= mem[idx_a];
        if (rd_b) data_b_p0 <= mem[idx_b];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_a_p0 <= 1'b0;
            vld_b_p0 <= 1'b0;
            err_a_p0 <= 1'b0;
            err_b_p0 <= 1'b0;
        end else begin
            vld_a_p0 <= rd_a;
            vld_b_p0 <= rd_b;
            err_a_p0 <= err_a;
            err_b_p0 <= err_b;
        end
    end

`ifdef DATA_RAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] data_a_p1, data_b_p1;
    logic                  vld_a_p1, vld_b_p1, err_a_p1, err_b_p1;

    // Stage p1: optional output register, fully reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_a_p1 <= '0;
            data_b_p1 <= '0;
            vld_a_p1  <= 1'b0;
            vld_b_p1  <= 1'b0;
            err_a_p1  <= 1'b0;
            err_b_p1  <= 1'b0;
        end else begin
            data_a_p1 <= vld_a_p0 ? data_a_p0 : '0;
            data_b_p1 <= vld_b_p0 ? data_b_p0 : '0;
            vld_a_p1  <= vld_a_p0;
            vld_b_p1  <= vld_b_p0;
            err_a_p1  <= err_a_p0;
            err_b_p1  <= err_b_p0;
        end
    end

    assign read_data_a  = data_a_p1;
    assign read_data_b  = data_b_p1;
    assign read_valid_a = vld_a_p1;
    assign read_valid_b = vld_b_p1;
    assign addr_error_a = err_a_p1;
    assign addr_error_b = err_b_p1;
`else
    assign read_data_a  = vld_a_p0 ? data_a_p0 : '0;
    assign read_data_b  = vld_b_p0 ? data_b_p0 : '0;
    assign read_valid_a = vld_a_p0;
    assign read_valid_b = vld_b_p0;
    assign addr_error_a = err_a_p0;
    assign addr_error_b = err_b_p0;
`endif

endmodule

// File: tb/tb_data_ram_dp_sweep.sv
// Scoreboard bench for data_ram_dp_sweep (DEPTH=16): directed stimulus pushes expected
// responses into a queue, a negedge monitor pops and compares them when they fall due.
module tb_data_ram_dp_sweep;

`ifdef DATA_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear_start = 1'b0;
    logic        busy;
    logic        read_enable_a = 1'b0, write_enable_a = 1'b0;
    logic [4:0]  address_a = '0;
    logic [23:0] write_data_a = '0;
    logic [23:0] read_data_a;
    logic        read_valid_a, addr_error_a;
    logic        read_enable_b = 1'b0, write_enable_b = 1'b0;
    logic [4:0]  address_b = '0;
    logic [23:0] write_data_b = '0;
    logic [23:0] read_data_b;
    logic        read_valid_b, addr_error_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        logic        va;
        logic [23:0] da;
        logic        ea;
        logic        vb;
        logic [23:0] db;
        logic        eb;
    } exp_t;

    exp_t exp_q[$];

    data_ram_dp_sweep #(
        .DATA_WIDTH(24),
        .DEPTH(16),
        .ADDR_WIDTH(5),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .clear_start(clear_start),
        .busy(busy),
        .read_enable_a(read_enable_a),
        .write_enable_a(write_enable_a),
        .address_a(address_a),
        .write_data_a(write_data_a),
        .read_data_a(read_data_a),
        .read_valid_a(read_valid_a),
        .addr_error_a(addr_error_a),
        .read_enable_b(read_enable_b),
        .write_enable_b(write_enable_b),
        .address_b(address_b),
        .write_data_b(write_data_b),
        .read_data_b(read_data_b),
        .read_valid_b(read_valid_b),
        .addr_error_b(addr_error_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare the due expectation, or demand quiet outputs when nothing is due.
    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            chk("read_valid_a", 32'(read_valid_a), 32'(e.va));
            chk("read_data_a",  32'(read_data_a),  32'(e.da));
            chk("addr_error_a", 32'(addr_error_a), 32'(e.ea));
            chk("read_valid_b", 32'(read_valid_b), 32'(e.vb));
            chk("read_data_b",  32'(read_data_b),  32'(e.db));
            chk("addr_error_b", 32'(addr_error_b), 32'(e.eb));
        end else begin
            chk("idle_outputs",
                {4'd0, read_valid_a, addr_error_a, read_valid_b, addr_error_b, read_data_a},
                32'd0);
            chk("idle_data_b", 32'(read_data_b), 32'd0);
        end
    end

    task automatic port_a(input logic re, input logic we, input logic [4:0] addr, input logic [23:0] wd);
        read_enable_a  = re;
        write_enable_a = we;
        address_a      = addr;
        write_data_a   = wd;
    endtask

    task automatic port_b(input logic re, input logic we, input logic [4:0] addr, input logic [23:0] wd);
        read_enable_b  = re;
        write_enable_b = we;
        address_b      = addr;
        write_data_b   = wd;
    endtask

    // Issue the currently driven request for one clock and queue its expected response.
    task automatic step(input logic exp_busy,
                        input logic va, input logic [23:0] da, input logic ea,
                        input logic vb, input logic [23:0] db, input logic eb);
        exp_t e;
        chk("busy", 32'(busy), 32'(exp_busy));
        e.due = cyc + LAT;
        e.va = va; e.da = da; e.ea = ea;
        e.vb = vb; e.db = db; e.eb = eb;
        exp_q.push_back(e);
        @(posedge clock);
        @(negedge clock);
        clear_start = 1'b0;
        port_a(1'b0, 1'b0, 5'd0, 24'd0);
        port_b(1'b0, 1'b0, 5'd0, 24'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_rd_a", {7'd0, read_valid_a, read_data_a}, 32'd0);
        chk("reset_rd_b", {7'd0, read_valid_b, read_data_b}, 32'd0);
        reset = 1'b0;

        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clock);
            @(negedge clock);
        end
        chk("initial_sweep_len", 32'(n), 32'd16);

        for (int i = 0; i < 16; i++) begin
            port_a(1'b1, 1'b0, 5'(i), 24'd0);
            port_b(1'b1, 1'b0, 5'(15 - i), 24'd0);
            step(1'b0, 1'b1, 24'd0, 1'b0, 1'b1, 24'd0, 1'b0);
        end

        port_a(1'b0, 1'b1, 5'd5, 24'hABCDEF);
        step(1'b0, 1'b0, 24'd0, 1'b0, 1'b0, 24'd0, 1'b0);
        port_b(1'b1, 1'b0, 5'd5, 24'd0);
        step(1'b0, 1'b0, 24'd0, 1'b0, 1'b1, 24'hABCDEF, 1'b0);

        port_a(1'b0, 1'b1, 5'd3, 24'h111111);
        port_b(1'b0, 1'b1, 5'd3, 24'h222222);
        step(1'b0, 1'b0, 24'd0, 1'b0, 1'b0, 24'd0, 1'b0);
        port_a(1'b1, 1'b0, 5'd3, 24'd0);
        port_b(1'b1, 1'b0, 5'd3, 24'd0);
        step(1'b0, 1'b1, 24'h111111, 1'b0, 1'b1, 24'h111111, 1'b0);

        port_a(1'b0, 1'b1, 5'd7, 24'h000001);
        step(1'b0, 1'b0, 24'd0, 1'b0, 1'b0, 24'd0, 1'b0);
        port_a(1'b0, 1'b1, 5'd7, 24'h00FF00);
        port_b(1'b1, 1'b0, 5'd7, 24'd0);
        step(1'b0, 1'b0, 24'd0, 1'b0, 1'b1, 24'h000001, 1'b0);
        port_a(1'b1, 1'b0, 5'd7, 24'd0);
        step(1'b0, 1'b1, 24'h00FF00, 1'b0, 1'b0, 24'd0, 1'b0);

        port_a(1'b1, 1'b1, 5'd5, 24'h123456);
        step(1'b0, 1'b1, 24'hABCDEF, 1'b0, 1'b0, 24'd0, 1'b0);
        port_b(1'b1, 1'b0, 5'd5, 24'd0);
        step(1'b0, 1'b0, 24'd0, 1'b0, 1'b1, 24'h123456, 1'b0);

        port_b(1'b0, 1'b1, 5'd9, 24'h0A0B0C);
        port_a(1'b1, 1'b0, 5'd9, 24'd0);
        step(1'b0, 1'b1, 24'd0, 1'b0, 1'b0, 24'd0, 1'b0);
        port_a(1'b1, 1'b0, 5'd9, 24'd0);
        step(1'b0, 1'b1, 24'h0A0B0C, 1'b0, 1'b0, 24'd0, 1'b0);

        port_a(1'b1, 1'b0, 5'd20, 24'd0);
        port_b(1'b0, 1'b1, 5'd16, 24'hFFFFFF);
        step(1'b0, 1'b0, 24'd0, 1'b1, 1'b0, 24'd0, 1'b1);
        port_a(1'b0, 1'b1, 5'd20, 24'hDEAD00);
        port_b(1'b0, 1'b0, 5'd31, 24'd0);
        step(1'b0, 1'b0, 24'd0, 1'b1, 1'b0, 24'd0, 1'b0);
        port_a(1'b1, 1'b0, 5'd4, 24'd0);
        port_b(1'b1, 1'b0, 5'd0, 24'd0);
        step(1'b0, 1'b1, 24'd0, 1'b0, 1'b1, 24'd0, 1'b0);

        clear_start = 1'b1;
        port_a(1'b1, 1'b0, 5'd3, 24'd0);
        step(1'b0, 1'b1, 24'h111111, 1'b0, 1'b0, 24'd0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            port_a(1'b0, 1'b1, 5'd1, 24'h555555);
            port_b(1'b1, 1'b0, 5'd3, 24'd0);
            step(1'b1, 1'b0, 24'd0, 1'b0, 1'b0, 24'd0, 1'b0);
        end

        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("midsweep_reset_busy", 32'(busy), 32'd1);
        chk("midsweep_reset_rd_a", {6'd0, addr_error_a, read_valid_a, read_data_a}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            port_a(1'b0, 1'b1, 5'((i + 15) % 16), 24'h777777);
            port_b(1'b0, 1'b1, 5'((i + 14) % 16), 24'h888888);
            clear_start = (i == 9);
            step(1'b1, 1'b0, 24'd0, 1'b0, 1'b0, 24'd0, 1'b0);
        end

        for (int i = 0; i < 16; i++) begin
            port_a(1'b1, 1'b0, 5'(i), 24'd0);
            port_b(1'b1, 1'b0, 5'(15 - i), 24'd0);
            step(1'b0, 1'b1, 24'd0, 1'b0, 1'b1, 24'd0, 1'b0);
        end

        repeat (LAT + 2) @(posedge clock);
        @(negedge clock);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_ram_dp_sweep.md
Name: data_ram_dp_sweep

Overview:
- Parametrised, single-clock, true dual-port data memory for pixel/image buffers.
- Successor of the fixed 24-bit x 90000-word image RAM.
- Adds:
  - configurable width and depth;
  - a hardware clear sweep, because the array cannot be reset asynchronously;
  - read-valid strobes;
  - address-range checking;
  - defined collision rules.
- Sits between the processor's load/store path (port A) and the image DMA/display path (port B).

Parameters:
- DATA_WIDTH, 24: word width in bits.
- DEPTH, 90000: number of words; must be ≥ 2.
- ADDR_WIDTH, 17: address width; 2**ADDR_WIDTH must be ≥ DEPTH.
- CLEAR_ON_RESET, 1: 1 = clear sweep starts on reset release; 0 = ready immediately after reset.

Ports:
- clock, in, 1: single clock; all logic on posedge.
- reset, in, 1: asynchronous, active-high reset.
- clear_start, in, 1: one-cycle request to zero the whole array.
- busy, out, 1: high while a clear sweep runs.
- read_enable_a, in, 1: port A read request.
- write_enable_a, in, 1: port A write request.
- address_a, in, ADDR_WIDTH: port A word address.
- write_data_a, in, DATA_WIDTH: port A write data.
- read_data_a, out, DATA_WIDTH: port A read data.
- read_valid_a, out, 1: read_data_a holds the result of an accepted read.
- addr_error_a, out, 1: one-cycle pulse on an out-of-range port A access.
- Port B: read_enable_b, write_enable_b, address_b, write_data_b, read_data_b, read_valid_b, addr_error_b; identical to port A.

Behaviour:
- Reset:
  - While reset is high: all outputs are 0, clear pointer = 0.
  - State = CLEAR if CLEAR_ON_RESET=1, else READY.
  - busy reflects the state combinationally (busy=1 in CLEAR).
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle writes 0 to mem[ptr], then ptr += 1.
  - When ptr == DEPTH-1 is written, next state = READY and ptr = 0.
  - Full sweep takes exactly DEPTH cycles.
- READY → CLEAR: on clear_start=1, with ptr = 0. The port accesses in that same cycle are still served.
- clear_start while in CLEAR: ignored; the sweep does not restart.
- Reset asserted mid-sweep: sweep restarts from 0 after release (when CLEAR_ON_RESET=1). Contents are undefined until the sweep completes.
- Port access while busy=1:
  - Writes are dropped.
  - read_data = 0 and read_valid = 0 on the next cycle.
  - addr_error is not raised.
- Port access in READY, per port:
  - Read latency is 1 cycle: read_enable at edge N gives read_data/read_valid at edge N+1.
  - If read_enable=0, the next cycle has read_data = 0 and read_valid = 0.
  - Write updates mem[address] at the edge.
- Address ≥ DEPTH:
  - Write is dropped.
  - Read returns 0 with read_valid = 0.
  - addr_error = 1 for exactly the next cycle, only if read_enable or write_enable was high.
- Read-during-write, same port, same address: read-first; returns the old data.
- Cross-port, A writes address X while B reads X in the same cycle: B returns the old data. The symmetric case (B writes, A reads) behaves the same way.
- Both ports write the same address in the same cycle: port A's data is stored; port B's write is discarded, with no error flag.
- Memory has no reset or initial-file load. Initial contents are 0 only via the sweep.

Optional Feature:
- Macro: DATA_RAM_OUT_REG_EN.
- Defined:
  - Adds a second output register stage per port, so read latency is 2 cycles.
  - read_valid and addr_error are delayed to stay aligned with read_data.
  - The extra stage is reset to 0.
  - Collision and busy rules are unchanged, evaluated at request time.
- Undefined: latency 1 as above.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=16:
  - Release reset → busy=1 for exactly 16 cycles, then 0.
  - Read all 16 addresses → each returns 0 with read_valid=1.
- Write A addr 5 = 0xABCDEF, next cycle read B addr 5 → read_data_b = 0xABCDEF one cycle after the read, read_valid_b=1.
- Same cycle: A writes addr 3 = 0x111111, B writes addr 3 = 0x222222 → a later read of addr 3 returns 0x111111.
- Same cycle: A writes addr 7 = 0x00FF00 (old value 0x000001), B reads addr 7 → B gets 0x000001; the next read gets 0x00FF00.
- DEPTH=16: read A addr 20 → read_data_a=0, read_valid_a=0, addr_error_a high for 1 cycle. Write B addr 16 → addr_error_b pulse and the array is unchanged.
- Pulse clear_start after writing data, and assert reset at sweep cycle 8:
  - busy stays 1.
  - The sweep restarts after release and lasts 16 cycles.
  - All reads then return 0.
  - Port writes attempted during busy are absent.
